// File: rtl/layer_pass_scheduler.sv
// Walks every pixel of a frame in raster order and, per pixel, every enabled layer:
// restarts the ALU, waits for it (with timeout), then hands the result downstream.
module layer_pass_scheduler #(
  parameter int HOR_PIX    = 480,
  parameter int VER_PIX    = 272,
  parameter int NUM_LAYERS = 8,
  parameter int TIMEOUT    = 1023,
  localparam int LW = $clog2(NUM_LAYERS),
  localparam int XW = $clog2(HOR_PIX),
  localparam int YW = $clog2(VER_PIX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_enable,
  input  logic                  alu_rdy,
  input  logic                  result_ready,
  output logic [LW-1:0]         layer_sel,
  output logic                  pipe_adv,
  output logic [XW:0]           x_pixel,
  output logic [YW:0]           y_pixel,
  output logic                  result_valid,
  output logic                  result_last,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [XW:0]   X_MAX  = (XW + 1)'(HOR_PIX - 1);
  localparam logic [YW:0]   Y_MAX  = (YW + 1)'(VER_PIX - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, OUT} state_t;

  state_t                state, state_nxt;
  logic [NUM_LAYERS-1:0] mask;
  logic [CW-1:0]         wait_cnt;
  logic [LW-1:0]         lo_en, lo_mask, nxt_layer;
  logic                  has_above;
  logic                  start_ok, x_last, y_last;

  assign start_ok = frame_start & ~abort;
  assign x_last   = (x_pixel == X_MAX);
  assign y_last   = (y_pixel == Y_MAX);

  // Priority searches: lowest enabled layer (new frame / new pixel) and next one above layer_sel.
  always_comb begin
    lo_en     = '0;
    lo_mask   = '0;
    nxt_layer = '0;
    has_above = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_enable[i]) lo_en = LW'(i);
      if (mask[i]) lo_mask = LW'(i);
      if (mask[i] && (LW'(i) > layer_sel)) begin
        nxt_layer = LW'(i);
        has_above = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok && (layer_enable != '0)) state_nxt = LOAD;
      LOAD:    state_nxt = SETTLE;
      SETTLE:  state_nxt = WAIT;
      WAIT:    if (alu_rdy || (wait_cnt == T_LAST)) state_nxt = OUT;
      OUT:     if (result_ready)
                 state_nxt = (!has_above && x_last && y_last) ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask        <= '0;
      layer_sel   <= '0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (start_ok) begin
          mask        <= layer_enable;
          x_pixel     <= '0;
          y_pixel     <= '0;
          timeout_err <= 1'b0;
          layer_sel   <= lo_en;
          frame_done  <= (layer_enable == '0);
        end
        SETTLE: wait_cnt <= '0;
        WAIT: if (!alu_rdy) begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == T_LAST) timeout_err <= 1'b1;
        end
        OUT: if (result_ready) begin
          if (has_above) begin
            layer_sel <= nxt_layer;
          end else begin
            layer_sel <= lo_mask;
            if (!x_last) begin
              x_pixel <= x_pixel + 1'b1;
            end else begin
              x_pixel <= '0;
              if (!y_last) begin
                y_pixel <= y_pixel + 1'b1;
              end else begin
                y_pixel    <= '0;
                frame_done <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
      // Abort drops the frame silently; the sticky error survives it.
      if (abort && (state != IDLE)) begin
        x_pixel    <= '0;
        y_pixel    <= '0;
        frame_done <= 1'b0;
      end
    end
  end

  assign pipe_adv     = (state == LOAD);
  assign result_valid = (state == OUT);
  assign result_last  = (state == OUT) && !has_above;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_layer_pass_scheduler.sv
// Scoreboarded bench: directed frames push expected results; a negedge monitor checks each handshake.
module tb_layer_pass_scheduler;
  localparam int HP = 4, VP = 2, NL = 4, TO = 8;

  logic          clk = 1'b0, rst = 1'b0;
  logic          frame_start = 1'b0, abort = 1'b0, alu_rdy = 1'b0, result_ready = 1'b0;
  logic [NL-1:0] layer_enable = '0;
  logic [1:0]    layer_sel;
  logic          pipe_adv, result_valid, result_last, frame_done, busy, timeout_err;
  logic [2:0]    x_pixel;
  logic [1:0]    y_pixel;

  layer_pass_scheduler #(.HOR_PIX(HP), .VER_PIX(VP), .NUM_LAYERS(NL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .layer_enable(layer_enable), .alu_rdy(alu_rdy), .result_ready(result_ready),
    .layer_sel(layer_sel), .pipe_adv(pipe_adv), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .result_valid(result_valid), .result_last(result_last), .frame_done(frame_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  typedef struct { int x; int y; int l; int last; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected results for the first npix raster pixels, layers ascending, last = highest enabled.
  task automatic push_exp(input int npix, input logic [3:0] m);
    int   top;
    exp_t e;
    top = 0;
    for (int l = 0; l < 4; l++) if (m[l]) top = l;
    for (int p = 0; p < npix; p++)
      for (int l = 0; l < 4; l++)
        if (m[l]) begin
          e.x = p % HP; e.y = p / HP; e.l = l; e.last = (l == top) ? 1 : 0;
          q.push_back(e);
        end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid && result_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual x=%0d y=%0d layer=%0d required none", x_pixel, y_pixel, layer_sel);
      end else begin
        e = q.pop_front();
        chk("res_x", x_pixel, e.x);
        chk("res_y", y_pixel, e.y);
        chk("res_layer", layer_sel, e.l);
        chk("res_last", result_last, e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    layer_enable = m; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int got;
    got = 0;
    for (int i = 0; i < bound && got == 0; i++) begin
      @(negedge clk);
      if (frame_done) got = 1;
    end
    chk(name, got, 1);
  endtask

  task automatic wait_valid(input string name, input int bound);
    int got;
    got = 0;
    for (int i = 0; i < bound && got == 0; i++) begin
      @(negedge clk);
      if (result_valid) got = 1;
    end
    chk(name, got, 1);
  endtask

  initial begin
    int cyc, first_load, done_at, valid_at, adv_cnt, hit, snap, ndone;

    #1 rst = 1'b1;
    #4;
    chk("rst_outputs", {busy, result_valid, result_last, pipe_adv, frame_done, timeout_err}, 0);
    chk("rst_pos", {layer_sel, x_pixel, y_pixel}, 0);
    tick(); tick();
    rst = 1'b0;

    // Frame 1: mask 1011, no stalls; mid-frame start and mask change must be ignored.
    alu_rdy = 1'b1; result_ready = 1'b1;
    push_exp(HP * VP, 4'b1011);
    tick();
    pulse_start(4'b1011);
    cyc = 0; first_load = -1; done_at = -1; adv_cnt = 0;
    for (int i = 0; i < 300 && done_at < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (pipe_adv) begin
        adv_cnt++;
        if (first_load < 0) first_load = cyc;
      end
      if (frame_done) begin
        done_at = cyc;
        chk("f1_busy_at_done", busy, 0);
      end
      if (i == 20) begin frame_start = 1'b1; layer_enable = 4'b0001; end
      if (i == 21) frame_start = 1'b0;
    end
    chk("f1_done_latency", done_at - first_load, 96);
    chk("f1_pipe_adv_count", adv_cnt, 24);
    chk("f1_queue_drained", q.size(), 0);
    @(negedge clk);
    chk("f1_done_one_cycle", frame_done, 0);

    // Frame 2: backpressure on the first result.
    result_ready = 1'b0;
    push_exp(HP * VP, 4'b1011);
    tick();
    pulse_start(4'b1011);
    wait_valid("bp_valid_seen", 20);
    chk("bp_first_layer", layer_sel, 0);
    chk("bp_first_last", result_last, 0);
    snap = {layer_sel, x_pixel, y_pixel, result_last};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", result_valid, 1);
      chk("bp_outputs_hold", {layer_sel, x_pixel, y_pixel, result_last}, snap);
    end
    @(posedge clk); #1 result_ready = 1'b1;
    wait_done("bp_frame_done", 300);
    chk("bp_queue_drained", q.size(), 0);

    // Empty mask: immediate frame_done, no ALU restart.
    tick();
    pulse_start(4'b0000);
    chk("m0_done", frame_done, 1);
    chk("m0_busy", busy, 0);
    adv_cnt = 0;
    tick();
    chk("m0_done_clear", frame_done, 0);
    for (int k = 0; k < 5; k++) begin
      if (pipe_adv || busy) adv_cnt++;
      tick();
    end
    chk("m0_no_activity", adv_cnt, 0);

    // Timeout: alu_rdy stuck low on the first pixel.
    alu_rdy = 1'b0; result_ready = 1'b0;
    push_exp(HP * VP, 4'b0001);
    tick();
    pulse_start(4'b0001);
    cyc = 0; first_load = -1; valid_at = -1;
    for (int i = 0; i < 60 && valid_at < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (pipe_adv && first_load < 0) begin
        first_load = cyc;
        chk("to_err_clear_before", timeout_err, 0);
      end
      if (result_valid) begin
        valid_at = cyc;
        chk("to_err_set", timeout_err, 1);
      end
    end
    chk("to_wait_len", valid_at - first_load, 10);
    tick();
    alu_rdy = 1'b1; result_ready = 1'b1;
    wait_done("to_frame_done", 200);
    chk("to_err_sticky", timeout_err, 1);
    chk("to_queue_drained", q.size(), 0);

    // Abort during WAIT at pixel (2,1); the new start clears timeout_err.
    push_exp(6, 4'b1011);
    tick();
    pulse_start(4'b1011);
    chk("start_clears_to_err", timeout_err, 0);
    hit = 0;
    for (int i = 0; i < 200 && hit == 0; i++) begin
      @(negedge clk);
      if (result_valid && result_last && x_pixel == 3'd1 && y_pixel == 2'd1) begin
        alu_rdy = 1'b0; hit = 1;
      end
    end
    chk("ab_reached_pixel", hit, 1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("ab_wait_pos", {x_pixel, y_pixel}, {3'd2, 2'd1});
    chk("ab_wait_state", {busy, result_valid, pipe_adv}, 3'b100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_idle", {busy, result_valid, pipe_adv}, 0);
    chk("ab_pos_zero", {x_pixel, y_pixel}, 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (frame_done || busy) ndone++;
    end
    chk("ab_no_done", ndone, 0);
    chk("ab_queue_drained", q.size(), 0);

    // Simultaneous start and abort in IDLE: no start.
    alu_rdy = 1'b1;
    tick();
    layer_enable = 4'b1011; frame_start = 1'b1; abort = 1'b1;
    tick();
    frame_start = 1'b0; abort = 1'b0;
    chk("sa_no_start", busy, 0);
    tick();
    chk("sa_no_adv", {busy, pipe_adv}, 0);

    // Asynchronous reset while a result is stalled in OUT.
    result_ready = 1'b0;
    tick();
    pulse_start(4'b0001);
    wait_valid("rst_out_reached", 20);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", result_valid, 0);
    chk("rst_async_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("rst_final_queue", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/layer_pass_scheduler.md
Name: layer_pass_scheduler

Overview:
- Sequences the address calculation unit across every screen pixel and every enabled layer of a frame.
- Per layer: selects the layer register set, pulses the pipeline restart, waits for the ALU ready, then hands the result slot to the downstream blender with a valid/ready handshake.
- Walks pixels in raster order and reports frame completion.
- Sits between the frame controller and the ALU stage of the GPU pipeline.

Parameters:
- HOR_PIX, 480, screen width in pixels.
- VER_PIX, 272, screen height in pixels.
- NUM_LAYERS, 8, number of layer register sets; derived LW = $clog2(NUM_LAYERS).
- TIMEOUT, 1023, maximum WAIT cycles for ALU ready before forcing progress.
- Derived: XW = $clog2(HOR_PIX), YW = $clog2(VER_PIX).

Ports:
- clk  in  1  pipeline clock, 50 MHz max.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; starts a frame when idle.
- abort  in  1  one-cycle pulse; cancels the frame in progress.
- layer_enable  in  NUM_LAYERS  per-layer enable mask; sampled on an accepted frame_start.
- alu_rdy  in  1  ALU finished the current layer.
- result_ready  in  1  downstream accepts the result.
- layer_sel  out  LW  index of the layer register set driven to the ALU.
- pipe_adv  out  1  one-cycle restart strobe to the ALU (drives its pipeline reset).
- x_pixel  out  XW+1  current pixel column.
- y_pixel  out  YW+1  current pixel row.
- result_valid  out  1  ALU result for (x_pixel, y_pixel, layer_sel) is available.
- result_last  out  1  qualifies result_valid; marks the last enabled layer of this pixel.
- frame_done  out  1  one-cycle pulse after the final pixel is accepted.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set on any ALU timeout, cleared by an accepted frame_start.

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0, latched mask 0.
- States: IDLE, LOAD, SETTLE, WAIT, OUT.
- IDLE:
  - On frame_start: latch the mask, set x = y = 0, clear timeout_err, set layer_sel to the lowest enabled index, go to LOAD.
  - If the mask is all zero: pulse frame_done on the next cycle and stay in IDLE.
- LOAD: pipe_adv = 1 for exactly this cycle; go to SETTLE.
- SETTLE: alu_rdy is ignored for one cycle; go to WAIT; clear the wait counter.
- WAIT:
  - alu_rdy = 1 → go to OUT.
  - Otherwise increment the wait counter. When it reaches TIMEOUT, set timeout_err and go to OUT.
- OUT:
  - result_valid = 1. result_last = 1 when no enabled layer exists above layer_sel.
  - Hold result_valid, result_last, layer_sel, x_pixel and y_pixel stable until result_ready = 1.
  - On handshake, when not last: layer_sel moves to the next higher enabled index (priority search); go to LOAD.
  - On handshake, when last: layer_sel returns to the lowest enabled index. If x < HOR_PIX-1, x++. Otherwise x = 0; then if y < VER_PIX-1, y++ and go to LOAD; else pulse frame_done on the next cycle, zero x/y and go to IDLE.
- Minimum per-layer cost is 4 cycles: LOAD, SETTLE, WAIT with rdy, OUT with ready.
- A full frame with N enabled layers and zero stalls takes exactly 4·N·HOR_PIX·VER_PIX cycles from the LOAD after frame_start to frame_done.
- frame_start outside IDLE is ignored. A simultaneous frame_start and abort in IDLE: abort wins (no start).
- abort in any non-IDLE state:
  - Next cycle IDLE; result_valid, pipe_adv and busy are 0; x/y are zeroed.
  - No frame_done. timeout_err is preserved.
- The mask is frozen for the frame; layer_enable changes mid-frame have no effect.
- Reset asserted mid-frame forces the reset values immediately (asynchronous).

Test Plan:
- Use HOR_PIX=4, VER_PIX=2, NUM_LAYERS=4, mask 4'b1011, alu_rdy = 1 and result_ready = 1 always:
  - Expected layer_sel sequence per pixel: 0, 1, 3; result_last only on layer 3.
  - 24 results in total; frame_done pulses exactly 96 cycles after the first LOAD; pipe_adv count is 24.
- Backpressure: hold result_ready = 0 for 5 cycles in OUT → result_valid and all outputs stable; after ready, the sequence continues unchanged.
- Timeout with TIMEOUT = 8 and alu_rdy held 0:
  - OUT is entered after 8 WAIT cycles and timeout_err = 1.
  - The next frame_start clears timeout_err.
- Raster wrap: result_last accepted at x=3, y=0 → x=0, y=1. At x=3, y=1 → frame_done pulse, busy = 0.
- Mask 0 on frame_start → frame_done pulses 1 cycle later, pipe_adv never asserts. A frame_start while busy is ignored.
- abort during WAIT at pixel (2,1) → IDLE next cycle, no frame_done, x_pixel = y_pixel = 0. An async rst pulse mid-OUT clears result_valid immediately.
